control_sequencer: RTL and testbench

Hardwired control unit for the RISC datapath: it replaces hand-driven T-state control with an FSM that fetches each instruction, decodes the opcode from IR, and drives every DataPath control strobe through a per-class T3..T7 micro-sequence. It has configurable memory wait states, run/halt control and a sampled branch-condition path. It sits beside DataPath, consuming `IR[31:27]` and `ConOut`.

---
 rtl/cpu_ctrl_pkg.sv | 107 ++++++++++
 rtl/control_sequencer_if.sv | 30 +++
 rtl/opcode_decoder.sv | 75 +++++++
 rtl/control_sequencer.sv | 264 ++++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared definitions for the control_sequencer slice.
//   - opcode encodings (IR[31:27])
//   - opcode-class and FSM state enums
//   - ALU operation codes
//   - strobes_t: every DataPath strobe, in the order used by the top.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_SHR  = 5'd7;
    localparam logic [4:0] OP_SHRA = 5'd8;
    localparam logic [4:0] OP_SHL  = 5'd9;
    localparam logic [4:0] OP_ROR  = 5'd10;
    localparam logic [4:0] OP_ROL  = 5'd11;
    localparam logic [4:0] OP_ADDI = 5'd12;
    localparam logic [4:0] OP_ANDI = 5'd13;
    localparam logic [4:0] OP_ORI  = 5'd14;
    localparam logic [4:0] OP_MUL  = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16;
    localparam logic [4:0] OP_NEG  = 5'd17;
    localparam logic [4:0] OP_NOT  = 5'd18;
    localparam logic [4:0] OP_BR   = 5'd19;
    localparam logic [4:0] OP_JR   = 5'd20;
    localparam logic [4:0] OP_JAL  = 5'd21;
    localparam logic [4:0] OP_IN   = 5'd22;
    localparam logic [4:0] OP_OUT  = 5'd23;
    localparam logic [4:0] OP_MFHI = 5'd24;
    localparam logic [4:0] OP_MFLO = 5'd25;
    localparam logic [4:0] OP_NOP  = 5'd26;
    localparam logic [4:0] OP_HALT = 5'd27;
    // 28..31 are undefined.

    // ALU codes: register ops reuse their opcode; immediates map onto these.
    localparam logic [4:0] ALU_ADD = OP_ADD;
    localparam logic [4:0] ALU_AND = OP_AND;
    localparam logic [4:0] ALU_OR  = OP_OR;
    localparam logic [4:0] ALU_INC = 5'b11111;

    // Memory wait-state counter width (MEM_WAIT is 0..7).
    localparam int WAIT_W = 3;

    typedef enum logic [3:0] {
        CLS_ALUR,
        CLS_ALUI,
        CLS_LD,
        CLS_LDI,
        CLS_ST,
        CLS_BR,
        CLS_JR,
        CLS_JAL,
        CLS_IN,
        CLS_OUT,
        CLS_MFHI,
        CLS_MFLO,
        CLS_MULDIV,
        CLS_NOP,
        CLS_HALT,
        CLS_ILL
    } op_class_e;

    typedef enum logic [3:0] {
        T0   = 4'd0,
        T1   = 4'd1,
        T2   = 4'd2,
        T3   = 4'd3,
        T4   = 4'd4,
        T5   = 4'd5,
        T6   = 4'd6,
        T7   = 4'd7,
        HALT = 4'd8
    } state_e;

    typedef struct packed {
        logic HiIn;
        logic LoIn;
        logic ZIn;
        logic PCIn;
        logic MDRIn;
        logic MARIn;
        logic YIn;
        logic OPortIn;
        logic IRIn;
        logic HiOut;
        logic LoOut;
        logic ZHiOut;
        logic ZLoOut;
        logic PCOut;
        logic MDROut;
        logic IPortOut;
        logic COut;
        logic Gra;
        logic Grb;
        logic Grc;
        logic RIn;
        logic ROut;
        logic BAOut;
        logic Conin;
        logic memread;
        logic memwrite;
    } strobes_t;

endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: DataPath control bus driven by the sequencer.
//   Load strobes : HiIn LoIn ZIn PCIn MDRIn MARIn YIn OPortIn IRIn
//   Bus drivers  : HiOut LoOut ZHiOut ZLoOut PCOut MDROut IPortOut COut
//   Reg file/CON : Gra Grb Grc RIn ROut BAOut Conin
//   Memory       : memread memwrite
//   ALU          : ALUCode [ALU_W-1:0]
// Modports: master (sequencer, drives everything), slave (DataPath).
interface control_sequencer_if #(
    parameter int ALU_W = 5
);
    logic HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn;
    logic HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut;
    logic Gra, Grb, Grc, RIn, ROut, BAOut, Conin;
    logic memread, memwrite;
    logic [ALU_W-1:0] ALUCode;

    modport master (
        output HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn,
        output HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut,
        output Gra, Grb, Grc, RIn, ROut, BAOut, Conin,
        output memread, memwrite, ALUCode
    );

    modport slave (
        input HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn,
        input HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut,
        input Gra, Grb, Grc, RIn, ROut, BAOut, Conin,
        input memread, memwrite, ALUCode
    );
endinterface

// File: rtl/opcode_decoder.sv
// opcode_decoder: combinational opcode -> instruction class + ALU code.
//   opcode_i   : IR[31:27]
//   op_class_o : execute-sequence class
//   alu_code_o : ALU operation for the class's ALU step (0 if none)
// Build option MULDIV_EN: when defined, mul/div decode as their own class;
// otherwise they fall into the illegal class.
module opcode_decoder
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 5,
    parameter int ALU_W    = 5
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    output op_class_e           op_class_o,
    output logic [ALU_W-1:0]    alu_code_o
);

    always_comb begin
        op_class_o = CLS_ILL;
        alu_code_o = '0;
        case (opcode_i)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
            OP_ROR, OP_ROL, OP_NEG, OP_NOT: begin
                op_class_o = CLS_ALUR;
                alu_code_o = ALU_W'(opcode_i);
            end
            OP_ADDI: begin
                op_class_o = CLS_ALUI;
                alu_code_o = ALU_W'(ALU_ADD);
            end
            OP_ANDI: begin
                op_class_o = CLS_ALUI;
                alu_code_o = ALU_W'(ALU_AND);
            end
            OP_ORI: begin
                op_class_o = CLS_ALUI;
                alu_code_o = ALU_W'(ALU_OR);
            end
            OP_LD: begin
                op_class_o = CLS_LD;
                alu_code_o = ALU_W'(ALU_ADD);
            end
            OP_LDI: begin
                op_class_o = CLS_LDI;
                alu_code_o = ALU_W'(ALU_ADD);
            end
            OP_ST: begin
                op_class_o = CLS_ST;
                alu_code_o = ALU_W'(ALU_ADD);
            end
            OP_BR: begin
                op_class_o = CLS_BR;
                alu_code_o = ALU_W'(ALU_ADD);
            end
            OP_JR:   op_class_o = CLS_JR;
            OP_JAL:  op_class_o = CLS_JAL;
            OP_IN:   op_class_o = CLS_IN;
            OP_OUT:  op_class_o = CLS_OUT;
            OP_MFHI: op_class_o = CLS_MFHI;
            OP_MFLO: op_class_o = CLS_MFLO;
            OP_NOP:  op_class_o = CLS_NOP;
            OP_HALT: op_class_o = CLS_HALT;
`ifdef MULDIV_EN
            OP_MUL, OP_DIV: begin
                op_class_o = CLS_MULDIV;
                alu_code_o = ALU_W'(opcode_i);
            end
`else
            OP_MUL, OP_DIV: op_class_o = CLS_ILL;
`endif
            default: op_class_o = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired T-state control unit for the RISC DataPath.
// Fetches (T0..T2), decodes IR[31:27] and walks a per-class T3..T7 sequence.
//   clock      : rising-edge clock
//   clear      : asynchronous active-low reset; also forces all outputs low
//   run        : 1 = fetch next instruction, 0 = stall in T0
//   opcode     : IR[31:27], valid from T3 on
//   ConOut     : branch condition flip-flop, used in br T6
//   bus        : control_sequencer_if.master, every DataPath strobe + ALUCode
//   halted     : high while in HALT
//   illegal_op : one-cycle pulse in T3 for an undecodable opcode
//   state      : current state (debug)
// Build option MULDIV_EN enables the mul/div sequence (see opcode_decoder).
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 5,
    parameter int ALU_W    = 5,
    parameter int MEM_WAIT = 0
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                ConOut,
    control_sequencer_if.master bus,
    output logic                halted,
    output logic                illegal_op,
    output logic [3:0]          state
);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    op_class_e         op_class;
    logic [ALU_W-1:0]  alu_code;
    logic              mem_state;
    strobes_t          stb;
    logic [ALU_W-1:0]  alu_out;

    opcode_decoder #(
        .OPCODE_W (OPCODE_W),
        .ALU_W    (ALU_W)
    ) u_dec (
        .opcode_i   (opcode),
        .op_class_o (op_class),
        .alu_code_o (alu_code)
    );

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= T0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // States that talk to memory and therefore stretch by MEM_WAIT cycles.
    always_comb begin
        mem_state = (state_q == T1)
                 || (state_q == T6 && op_class == CLS_LD)
                 || (state_q == T7 && op_class == CLS_ST);
    end

    // The wait counter is reloaded whenever we are not counting down, so it
    // always holds MEM_WAIT on entry to a memory state.
    always_comb begin
        state_d = state_q;
        wait_d  = WAIT_W'(MEM_WAIT);
        if (mem_state && wait_q != '0) begin
            wait_d = wait_q - 1'b1;
        end else begin
            case (state_q)
                T0: if (run) state_d = T1;
                T1: state_d = T2;
                T2: state_d = T3;
                // IR is only loaded at the end of T2, so the class decision
                // (including nop/halt/illegal) is taken in T3.
                T3: begin
                    case (op_class)
                        CLS_ALUR, CLS_ALUI, CLS_LD, CLS_LDI, CLS_ST,
                        CLS_BR, CLS_JAL, CLS_MULDIV: state_d = T4;
                        CLS_HALT:                    state_d = HALT;
                        default:                     state_d = T0;
                    endcase
                end
                T4: begin
                    if (op_class == CLS_JAL) state_d = T0;
                    else                     state_d = T5;
                end
                T5: begin
                    if (op_class inside {CLS_LD, CLS_ST, CLS_BR, CLS_MULDIV}) state_d = T6;
                    else                                                       state_d = T0;
                end
                T6: begin
                    if (op_class inside {CLS_LD, CLS_ST}) state_d = T7;
                    else                                  state_d = T0;
                end
                T7:      state_d = T0;
                HALT:    state_d = HALT;
                default: state_d = T0;
            endcase
        end
    end

    // Moore strobe decode; clear gates everything so a reset mid-instruction
    // silences the DataPath in the same cycle.
    always_comb begin
        stb     = '0;
        alu_out = '0;
        if (clear) begin
            case (state_q)
                T0: if (run) begin
                    stb.PCOut = 1'b1; stb.MARIn = 1'b1; stb.ZIn = 1'b1;
                    alu_out   = ALU_W'(ALU_INC);
                end
                T1: begin
                    stb.ZLoOut = 1'b1; stb.PCIn = 1'b1;
                    stb.memread = 1'b1; stb.MDRIn = 1'b1;
                end
                T2: begin
                    stb.MDROut = 1'b1; stb.IRIn = 1'b1;
                end
                T3: begin
                    case (op_class)
                        CLS_ALUR, CLS_ALUI: begin
                            stb.Grb = 1'b1; stb.ROut = 1'b1; stb.YIn = 1'b1;
                        end
                        CLS_LD, CLS_LDI, CLS_ST: begin
                            stb.Grb = 1'b1; stb.BAOut = 1'b1; stb.YIn = 1'b1;
                        end
                        CLS_BR: begin
                            stb.Gra = 1'b1; stb.ROut = 1'b1; stb.Conin = 1'b1;
                        end
                        CLS_JR: begin
                            stb.Gra = 1'b1; stb.ROut = 1'b1; stb.PCIn = 1'b1;
                        end
                        CLS_JAL: begin
                            stb.PCOut = 1'b1; stb.Grb = 1'b1; stb.RIn = 1'b1;
                        end
                        CLS_IN: begin
                            stb.IPortOut = 1'b1; stb.Gra = 1'b1; stb.RIn = 1'b1;
                        end
                        CLS_OUT: begin
                            stb.Gra = 1'b1; stb.ROut = 1'b1; stb.OPortIn = 1'b1;
                        end
                        CLS_MFHI: begin
                            stb.HiOut = 1'b1; stb.Gra = 1'b1; stb.RIn = 1'b1;
                        end
                        CLS_MFLO: begin
                            stb.LoOut = 1'b1; stb.Gra = 1'b1; stb.RIn = 1'b1;
                        end
                        CLS_MULDIV: begin
                            stb.Gra = 1'b1; stb.ROut = 1'b1; stb.YIn = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    case (op_class)
                        CLS_ALUR: begin
                            stb.Grc = 1'b1; stb.ROut = 1'b1; stb.ZIn = 1'b1;
                            alu_out = alu_code;
                        end
                        CLS_ALUI, CLS_LD, CLS_LDI, CLS_ST: begin
                            stb.COut = 1'b1; stb.ZIn = 1'b1;
                            alu_out  = alu_code;
                        end
                        CLS_BR: begin
                            stb.PCOut = 1'b1; stb.YIn = 1'b1;
                        end
                        CLS_JAL: begin
                            stb.Gra = 1'b1; stb.ROut = 1'b1; stb.PCIn = 1'b1;
                        end
                        CLS_MULDIV: begin
                            stb.Grb = 1'b1; stb.ROut = 1'b1; stb.ZIn = 1'b1;
                            alu_out = alu_code;
                        end
                        default: ;
                    endcase
                end
                T5: begin
                    case (op_class)
                        CLS_ALUR, CLS_ALUI, CLS_LDI: begin
                            stb.ZLoOut = 1'b1; stb.Gra = 1'b1; stb.RIn = 1'b1;
                        end
                        CLS_LD, CLS_ST: begin
                            stb.ZLoOut = 1'b1; stb.MARIn = 1'b1;
                        end
                        CLS_BR: begin
                            stb.COut = 1'b1; stb.ZIn = 1'b1;
                            alu_out  = alu_code;
                        end
                        CLS_MULDIV: begin
                            stb.ZLoOut = 1'b1; stb.LoIn = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    case (op_class)
                        CLS_LD: begin
                            stb.memread = 1'b1; stb.MDRIn = 1'b1;
                        end
                        CLS_ST: begin
                            stb.Gra = 1'b1; stb.ROut = 1'b1; stb.MDRIn = 1'b1;
                        end
                        // CON was loaded in T3, so ConOut is settled here.
                        CLS_BR: begin
                            stb.ZLoOut = 1'b1; stb.PCIn = ConOut;
                        end
                        CLS_MULDIV: begin
                            stb.ZHiOut = 1'b1; stb.HiIn = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T7: begin
                    case (op_class)
                        CLS_LD: begin
                            stb.MDROut = 1'b1; stb.Gra = 1'b1; stb.RIn = 1'b1;
                        end
                        CLS_ST:  stb.memwrite = 1'b1;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign bus.HiIn     = stb.HiIn;
    assign bus.LoIn     = stb.LoIn;
    assign bus.ZIn      = stb.ZIn;
    assign bus.PCIn     = stb.PCIn;
    assign bus.MDRIn    = stb.MDRIn;
    assign bus.MARIn    = stb.MARIn;
    assign bus.YIn      = stb.YIn;
    assign bus.OPortIn  = stb.OPortIn;
    assign bus.IRIn     = stb.IRIn;
    assign bus.HiOut    = stb.HiOut;
    assign bus.LoOut    = stb.LoOut;
    assign bus.ZHiOut   = stb.ZHiOut;
    assign bus.ZLoOut   = stb.ZLoOut;
    assign bus.PCOut    = stb.PCOut;
    assign bus.MDROut   = stb.MDROut;
    assign bus.IPortOut = stb.IPortOut;
    assign bus.COut     = stb.COut;
    assign bus.Gra      = stb.Gra;
    assign bus.Grb      = stb.Grb;
    assign bus.Grc      = stb.Grc;
    assign bus.RIn      = stb.RIn;
    assign bus.ROut     = stb.ROut;
    assign bus.BAOut    = stb.BAOut;
    assign bus.Conin    = stb.Conin;
    assign bus.memread  = stb.memread;
    assign bus.memwrite = stb.memwrite;
    assign bus.ALUCode  = alu_out;

    assign halted     = clear && (state_q == HALT);
    assign illegal_op = clear && (state_q == T3) && (op_class == CLS_ILL);
    assign state      = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed + random instruction streams for
// control_sequencer (MEM_WAIT = 2), checked cycle by cycle against a
// micro-step list built from the instruction-class rules.
module tb_control_sequencer;

    localparam int MW = 2;

    // Opcode encoding of the control unit.
    localparam logic [4:0] O_LD = 5'd0,  O_LDI = 5'd1,  O_ST = 5'd2,   O_ADD = 5'd3;
    localparam logic [4:0] O_SUB = 5'd4, O_AND = 5'd5,  O_OR = 5'd6,   O_SHR = 5'd7;
    localparam logic [4:0] O_SHRA = 5'd8, O_SHL = 5'd9, O_ROR = 5'd10, O_ROL = 5'd11;
    localparam logic [4:0] O_ADDI = 5'd12, O_ANDI = 5'd13, O_ORI = 5'd14, O_MUL = 5'd15;
    localparam logic [4:0] O_DIV = 5'd16, O_NEG = 5'd17, O_NOT = 5'd18, O_BR = 5'd19;
    localparam logic [4:0] O_JR = 5'd20, O_JAL = 5'd21, O_IN = 5'd22,  O_OUT = 5'd23;
    localparam logic [4:0] O_MFHI = 5'd24, O_MFLO = 5'd25, O_NOP = 5'd26, O_HALT = 5'd27;

    // One bit per strobe, HiIn at the top down to memwrite at bit 0.
    localparam logic [25:0] M_HIIN     = 26'h1 << 25;
    localparam logic [25:0] M_LOIN     = 26'h1 << 24;
    localparam logic [25:0] M_ZIN      = 26'h1 << 23;
    localparam logic [25:0] M_PCIN     = 26'h1 << 22;
    localparam logic [25:0] M_MDRIN    = 26'h1 << 21;
    localparam logic [25:0] M_MARIN    = 26'h1 << 20;
    localparam logic [25:0] M_YIN      = 26'h1 << 19;
    localparam logic [25:0] M_OPORTIN  = 26'h1 << 18;
    localparam logic [25:0] M_IRIN     = 26'h1 << 17;
    localparam logic [25:0] M_HIOUT    = 26'h1 << 16;
    localparam logic [25:0] M_LOOUT    = 26'h1 << 15;
    localparam logic [25:0] M_ZHIOUT   = 26'h1 << 14;
    localparam logic [25:0] M_ZLOOUT   = 26'h1 << 13;
    localparam logic [25:0] M_PCOUT    = 26'h1 << 12;
    localparam logic [25:0] M_MDROUT   = 26'h1 << 11;
    localparam logic [25:0] M_IPORTOUT = 26'h1 << 10;
    localparam logic [25:0] M_COUT     = 26'h1 << 9;
    localparam logic [25:0] M_GRA      = 26'h1 << 8;
    localparam logic [25:0] M_GRB      = 26'h1 << 7;
    localparam logic [25:0] M_GRC      = 26'h1 << 6;
    localparam logic [25:0] M_RIN      = 26'h1 << 5;
    localparam logic [25:0] M_ROUT     = 26'h1 << 4;
    localparam logic [25:0] M_BAOUT    = 26'h1 << 3;
    localparam logic [25:0] M_CONIN    = 26'h1 << 2;
    localparam logic [25:0] M_MEMREAD  = 26'h1 << 1;
    localparam logic [25:0] M_MEMWRITE = 26'h1;
    localparam logic [25:0] M_BUSDRV   = M_HIOUT | M_LOOUT | M_ZHIOUT | M_ZLOOUT | M_PCOUT
                                       | M_MDROUT | M_IPORTOUT | M_COUT | M_ROUT | M_BAOUT;

    localparam logic [4:0] A_ADD = 5'd3, A_AND = 5'd5, A_OR = 5'd6, A_INC = 5'b11111;

    // Step indices within an instruction: T0, T1 x (MW+1), T2, T3...
    localparam int IDX_T3 = MW + 3;
    localparam int IDX_T5 = MW + 5;

    typedef struct packed {
        logic [25:0] s;
        logic [4:0]  alu;
        logic [3:0]  t;
        logic        ill;
        logic        hlt;
    } step_t;

    logic       clock = 1'b0;
    logic       clear = 1'b0;
    logic       run = 1'b0;
    logic       ConOut = 1'b0;
    logic [4:0] opcode = 5'd0;
    logic       halted, illegal_op;
    logic [3:0] state;

    int passed = 0;
    int total  = 0;
    step_t exp_q[$];

    control_sequencer_if #(.ALU_W(5)) bus ();

    control_sequencer #(
        .OPCODE_W (5),
        .ALU_W    (5),
        .MEM_WAIT (MW)
    ) dut (
        .clock      (clock),
        .clear      (clear),
        .run        (run),
        .opcode     (opcode),
        .ConOut     (ConOut),
        .bus        (bus),
        .halted     (halted),
        .illegal_op (illegal_op),
        .state      (state)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [25:0] observe();
        return {bus.HiIn, bus.LoIn, bus.ZIn, bus.PCIn, bus.MDRIn, bus.MARIn, bus.YIn,
                bus.OPortIn, bus.IRIn, bus.HiOut, bus.LoOut, bus.ZHiOut, bus.ZLoOut,
                bus.PCOut, bus.MDROut, bus.IPortOut, bus.COut, bus.Gra, bus.Grb, bus.Grc,
                bus.RIn, bus.ROut, bus.BAOut, bus.Conin, bus.memread, bus.memwrite};
    endfunction

    function automatic step_t idle(input int t, input logic hlt);
        step_t e;
        e.s = '0; e.alu = '0; e.t = 4'(t); e.ill = 1'b0; e.hlt = hlt;
        return e;
    endfunction

    task automatic check(input step_t e, input string tag);
        step_t o;
        o.s = observe(); o.alu = bus.ALUCode; o.t = state;
        o.ill = illegal_op; o.hlt = halted;
        total++;
        assert (o === e) begin
            passed++;
        end else begin
            $error("FAIL %s: observed s=%h alu=%h t=%0d ill=%b hlt=%b expected s=%h alu=%h t=%0d ill=%b hlt=%b",
                   tag, o.s, o.alu, o.t, o.ill, o.hlt, e.s, e.alu, e.t, e.ill, e.hlt);
        end
        total++;
        assert (($countones(o.s & M_BUSDRV) <= 1) === 1'b1) begin
            passed++;
        end else begin
            $error("FAIL %s busdrv: observed drivers %h expected at most one", tag, o.s & M_BUSDRV);
        end
    endtask

    task automatic push(input logic [25:0] s, input logic [4:0] a, input int t,
                        input logic il, input int n);
        step_t e;
        e.s = s; e.alu = a; e.t = 4'(t); e.ill = il; e.hlt = 1'b0;
        repeat (n) exp_q.push_back(e);
    endtask

    // Reference: the micro-step list of one instruction, memory steps repeated.
    task automatic build(input logic [4:0] op, input logic con);
        exp_q.delete();
        push(M_PCOUT | M_MARIN | M_ZIN, A_INC, 0, 1'b0, 1);
        push(M_ZLOOUT | M_PCIN | M_MEMREAD | M_MDRIN, 5'd0, 1, 1'b0, MW + 1);
        push(M_MDROUT | M_IRIN, 5'd0, 2, 1'b0, 1);
        case (op)
            O_ADD, O_SUB, O_AND, O_OR, O_SHR, O_SHRA, O_SHL, O_ROR, O_ROL, O_NEG, O_NOT: begin
                push(M_GRB | M_ROUT | M_YIN, 5'd0, 3, 1'b0, 1);
                push(M_GRC | M_ROUT | M_ZIN, op, 4, 1'b0, 1);
                push(M_ZLOOUT | M_GRA | M_RIN, 5'd0, 5, 1'b0, 1);
            end
            O_ADDI, O_ANDI, O_ORI: begin
                push(M_GRB | M_ROUT | M_YIN, 5'd0, 3, 1'b0, 1);
                push(M_COUT | M_ZIN, (op == O_ADDI) ? A_ADD : (op == O_ANDI) ? A_AND : A_OR,
                     4, 1'b0, 1);
                push(M_ZLOOUT | M_GRA | M_RIN, 5'd0, 5, 1'b0, 1);
            end
            O_LD, O_ST, O_LDI: begin
                push(M_GRB | M_BAOUT | M_YIN, 5'd0, 3, 1'b0, 1);
                push(M_COUT | M_ZIN, A_ADD, 4, 1'b0, 1);
                if (op == O_LDI) begin
                    push(M_ZLOOUT | M_GRA | M_RIN, 5'd0, 5, 1'b0, 1);
                end else begin
                    push(M_ZLOOUT | M_MARIN, 5'd0, 5, 1'b0, 1);
                    if (op == O_LD) begin
                        push(M_MEMREAD | M_MDRIN, 5'd0, 6, 1'b0, MW + 1);
                        push(M_MDROUT | M_GRA | M_RIN, 5'd0, 7, 1'b0, 1);
                    end else begin
                        push(M_GRA | M_ROUT | M_MDRIN, 5'd0, 6, 1'b0, 1);
                        push(M_MEMWRITE, 5'd0, 7, 1'b0, MW + 1);
                    end
                end
            end
            O_BR: begin
                push(M_GRA | M_ROUT | M_CONIN, 5'd0, 3, 1'b0, 1);
                push(M_PCOUT | M_YIN, 5'd0, 4, 1'b0, 1);
                push(M_COUT | M_ZIN, A_ADD, 5, 1'b0, 1);
                push(M_ZLOOUT | (con ? M_PCIN : 26'h0), 5'd0, 6, 1'b0, 1);
            end
            O_JR:   push(M_GRA | M_ROUT | M_PCIN, 5'd0, 3, 1'b0, 1);
            O_JAL: begin
                push(M_PCOUT | M_GRB | M_RIN, 5'd0, 3, 1'b0, 1);
                push(M_GRA | M_ROUT | M_PCIN, 5'd0, 4, 1'b0, 1);
            end
            O_IN:   push(M_IPORTOUT | M_GRA | M_RIN, 5'd0, 3, 1'b0, 1);
            O_OUT:  push(M_GRA | M_ROUT | M_OPORTIN, 5'd0, 3, 1'b0, 1);
            O_MFHI: push(M_HIOUT | M_GRA | M_RIN, 5'd0, 3, 1'b0, 1);
            O_MFLO: push(M_LOOUT | M_GRA | M_RIN, 5'd0, 3, 1'b0, 1);
            O_MUL, O_DIV: begin
`ifdef MULDIV_EN
                push(M_GRA | M_ROUT | M_YIN, 5'd0, 3, 1'b0, 1);
                push(M_GRB | M_ROUT | M_ZIN, op, 4, 1'b0, 1);
                push(M_ZLOOUT | M_LOIN, 5'd0, 5, 1'b0, 1);
                push(M_ZHIOUT | M_HIIN, 5'd0, 6, 1'b0, 1);
`else
                push(26'h0, 5'd0, 3, 1'b1, 1);
`endif
            end
            O_NOP, O_HALT: push(26'h0, 5'd0, 3, 1'b0, 1);
            default:       push(26'h0, 5'd0, 3, 1'b1, 1);
        endcase
    endtask

    // Called at a falling edge with the DUT in T0; returns at the falling
    // edge where the next T0 begins (or after a clear pulse if abort_at hits).
    task automatic run_instr(input logic [4:0] op, input logic con,
                             input int drop_at, input int abort_at);
        string tag;
        tag = $sformatf("op%0d_con%0b", op, con);
        build(op, con);
        ConOut = con;
        opcode = 5'($urandom);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].t >= 4'd3) opcode = op;
            if (i == drop_at) run = 1'b0;
            #1;
            check(exp_q[i], $sformatf("%s_s%0d", tag, i));
            if (i == abort_at) begin
                clear = 1'b0;
                #1;
                check(idle(0, 1'b0), {tag, "_clear"});
                @(negedge clock);
                clear = 1'b1;
                return;
            end
            @(negedge clock);
        end
    endtask

    initial begin
        repeat (2) @(negedge clock);
        #1 check(idle(0, 1'b0), "reset");
        @(negedge clock);
        clear = 1'b1;
        repeat (2) begin
            #1 check(idle(0, 1'b0), "stall_run0");
            @(negedge clock);
        end
        run = 1'b1;

        run_instr(O_JR,   1'b0, -1, -1);
        run_instr(O_ADD,  1'b1, -1, -1);
        run_instr(O_BR,   1'b0, -1, -1);
        run_instr(O_BR,   1'b1, -1, -1);
        run_instr(O_ST,   1'b0, -1, -1);
        run_instr(O_LD,   1'b0, -1, -1);
        run_instr(O_MUL,  1'b0, -1, -1);
        run_instr(O_DIV,  1'b1, -1, -1);
        run_instr(O_LDI,  1'b0, -1, -1);
        run_instr(O_ADDI, 1'b0, -1, -1);
        run_instr(O_ANDI, 1'b1, -1, -1);
        run_instr(O_ORI,  1'b0, -1, -1);
        run_instr(O_JAL,  1'b0, -1, -1);
        run_instr(O_IN,   1'b0, -1, -1);
        run_instr(O_OUT,  1'b1, -1, -1);
        run_instr(O_MFHI, 1'b0, -1, -1);
        run_instr(O_MFLO, 1'b0, -1, -1);
        run_instr(O_NOP,  1'b0, -1, -1);
        run_instr(5'd30,  1'b0, -1, -1);
        run_instr(O_SUB,  1'b0, -1, -1);

        // run dropped mid-instruction: finish it, then sit idle in T0.
        run_instr(O_ADD, 1'b0, IDX_T3, -1);
        repeat (3) begin
            #1 check(idle(0, 1'b0), "run_dropped");
            @(negedge clock);
        end
        run = 1'b1;

        // clear during ld T5, then a normal fetch right after release.
        run_instr(O_LD, 1'b0, -1, IDX_T5);
        run_instr(O_OR, 1'b1, -1, -1);

        for (int n = 0; n < 24; n++) begin
            logic [4:0] op;
            logic       con;
            op  = 5'($urandom_range(0, 31));
            con = 1'($urandom_range(0, 1));
            if (op == O_HALT) op = O_NOP;
            run_instr(op, con, -1, -1);
        end

        // halt: parked until clear, regardless of run.
        run_instr(O_HALT, 1'b0, -1, -1);
        repeat (4) begin
            #1 check(idle(8, 1'b1), "halted");
            @(negedge clock);
        end
        clear = 1'b0;
        #1 check(idle(0, 1'b0), "halt_clear");
        @(negedge clock);
        clear = 1'b1;
        run_instr(O_ROL, 1'b0, -1, -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
